// File: rtl/shift_arbiter_if.sv
// Request/response bundle for the two-port shared barrel shifter.
// master = requester/consumer side, slave = the arbiter.
interface shift_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [1:0]      req0_sel;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_data;

  logic            req1_valid;
  logic            req1_ready;
  logic [1:0]      req1_sel;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_sel, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_sel, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_sel, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one 32-bit barrel shifter (SLL/SRL/SRA/pass).
// A single registered result stage holds one result and its owning port;
// a new op may be loaded in the same cycle the owner drains the old one.
module shift_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus,
  output logic           busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_p1, state_nxt;
  logic            owner_p1;
  logic            last_p1;
  logic [XLEN-1:0] result_p1;
  logic            vld_p1;

  logic            owner_ready;
  logic            can_accept;
  logic            gnt1;
  logic            accept;
  logic [1:0]      op_sel;
  logic [XLEN-1:0] op_a;
  logic [4:0]      op_amt;
  logic            unused_b_hi;

  function automatic logic [XLEN-1:0] do_shift(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] a,
                                                input logic [4:0]      amt);
    logic signed [XLEN-1:0] a_s;
    logic [XLEN-1:0]        r;
    a_s = a;
    case (sel)
      2'b01:   r = a << amt;
      2'b10:   r = a >> amt;
      2'b11:   r = a_s >>> amt;
      default: r = a;
    endcase
    return r;
  endfunction

  // Only b[4:0] carries the shift amount; upper bits are don't-care.
  assign unused_b_hi = ^{bus.req0_b[XLEN-1:5], bus.req1_b[XLEN-1:5]};

  // Arbitration: port 1 wins when alone, or on a tie when round-robin says
  // port 0 won last time. Readies are gated by reset so nothing is taken
  // while the block is held in reset.
  always_comb begin
    vld_p1      = (state_p1 == HOLD);
    owner_ready = owner_p1 ? bus.rsp1_ready : bus.rsp0_ready;
    can_accept  = rst_n & (~vld_p1 | owner_ready);
    gnt1        = bus.req1_valid &
                  (~bus.req0_valid | (RR_EN & ~last_p1));
    accept      = can_accept & (bus.req0_valid | bus.req1_valid);
    op_sel      = gnt1 ? bus.req1_sel : bus.req0_sel;
    op_a        = gnt1 ? bus.req1_a   : bus.req0_a;
    op_amt      = gnt1 ? bus.req1_b[4:0] : bus.req0_b[4:0];
  end

  assign bus.req0_ready = can_accept & bus.req0_valid & ~gnt1;
  assign bus.req1_ready = can_accept & gnt1;

  // Next-state: load on accept, drain to IDLE when owner takes and nothing new.
  always_comb begin
    state_nxt = state_p1;
    if (accept) begin
      state_nxt = HOLD;
    end else if (vld_p1 && owner_ready) begin
      state_nxt = IDLE;
    end
  end

  // ---- stage p1: result register, owner and round-robin history ----
  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      owner_p1 <= 1'b0;
      last_p1  <= 1'b1;
    end else begin
      state_p1 <= state_nxt;
      if (accept) begin
        owner_p1 <= gnt1;
        if (RR_EN) begin
          last_p1 <= gnt1;
        end
      end
    end
  end

  // Result register; loaded with the granted op's shift on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
    end else if (accept) begin
      result_p1 <= do_shift(op_sel, op_a, op_amt);
    end
  end

  assign bus.rsp0_valid = vld_p1 & ~owner_p1;
  assign bus.rsp1_valid = vld_p1 &  owner_p1;
  assign bus.rsp0_data  = result_p1;
  assign bus.rsp1_data  = result_p1;
  assign busy           = vld_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a per-cycle reference model of the
// pending-result / grant rules plus hand-computed literal results.
module tb_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v0, v1, rr0, rr1;
  logic [1:0]  s0, s1;
  logic [31:0] a0, b0, a1, b1;
  logic        busy_rr, busy_fp;

  shift_arbiter_if #(.XLEN(32)) bus_rr ();
  shift_arbiter_if #(.XLEN(32)) bus_fp ();

  assign bus_rr.req0_valid = v0;  assign bus_fp.req0_valid = v0;
  assign bus_rr.req0_sel   = s0;  assign bus_fp.req0_sel   = s0;
  assign bus_rr.req0_a     = a0;  assign bus_fp.req0_a     = a0;
  assign bus_rr.req0_b     = b0;  assign bus_fp.req0_b     = b0;
  assign bus_rr.rsp0_ready = rr0; assign bus_fp.rsp0_ready = rr0;
  assign bus_rr.req1_valid = v1;  assign bus_fp.req1_valid = v1;
  assign bus_rr.req1_sel   = s1;  assign bus_fp.req1_sel   = s1;
  assign bus_rr.req1_a     = a1;  assign bus_fp.req1_a     = a1;
  assign bus_rr.req1_b     = b1;  assign bus_fp.req1_b     = b1;
  assign bus_rr.rsp1_ready = rr1; assign bus_fp.rsp1_ready = rr1;

  shift_arbiter #(.XLEN(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr), .busy(busy_rr)
  );

  shift_arbiter #(.XLEN(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp), .busy(busy_fp)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference shift: one bit position per iteration with explicit fill.
  function automatic logic [31:0] ref_shift(input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    int n;
    r = a;
    n = int'(b % 32);
    for (int i = 0; i < n; i++) begin
      case (sel)
        2'b01:   r = {r[30:0], 1'b0};
        2'b10:   r = {1'b0, r[31:1]};
        2'b11:   r = {r[31], r[31:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Model: at most one pending result, its port and value, and who won last.
  bit          m_pend;
  int          m_port;
  logic [31:0] m_data;
  int          m_last;
  int          grant_log[$];

  always @(negedge clk) begin : model
    bit can;
    int win;
    if (!rst_n) begin
      m_pend = 0; m_port = 0; m_data = '0; m_last = 1;
      chk("rst_rsp0_valid", {31'b0, bus_rr.rsp0_valid}, 32'd0);
      chk("rst_rsp1_valid", {31'b0, bus_rr.rsp1_valid}, 32'd0);
      chk("rst_busy",       {31'b0, busy_rr},           32'd0);
      chk("rst_req0_ready", {31'b0, bus_rr.req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'b0, bus_rr.req1_ready}, 32'd0);
      chk("rst_data",       bus_rr.rsp0_data,           32'd0);
    end else begin
      chk("rsp0_valid", {31'b0, bus_rr.rsp0_valid}, {31'b0, m_pend && m_port == 0});
      chk("rsp1_valid", {31'b0, bus_rr.rsp1_valid}, {31'b0, m_pend && m_port == 1});
      chk("busy",       {31'b0, busy_rr},           {31'b0, m_pend});
      if (m_pend) begin
        chk(m_port == 0 ? "rsp0_data" : "rsp1_data",
            m_port == 0 ? bus_rr.rsp0_data : bus_rr.rsp1_data, m_data);
      end
      can = !m_pend || (m_port == 0 ? rr0 : rr1);
      if (v0 && v1) win = (m_last == 0) ? 1 : 0;
      else          win = v1 ? 1 : 0;
      chk("req0_ready", {31'b0, bus_rr.req0_ready}, {31'b0, can && v0 && win == 0});
      chk("req1_ready", {31'b0, bus_rr.req1_ready}, {31'b0, can && v1 && win == 1});
      if (can && (v0 || v1)) begin
        m_pend = 1;
        m_port = win;
        m_data = (win == 0) ? ref_shift(s0, a0, b0) : ref_shift(s1, a1, b1);
        m_last = win;
        grant_log.push_back(win);
      end else if (m_pend && (m_port == 0 ? rr0 : rr1)) begin
        m_pend = 0;
      end
    end
  end

  // Fixed-priority instance observation during the tie test.
  bit in_t3 = 0;
  int fp_acc0 = 0;
  int fp_r1 = 0;
  always @(negedge clk) begin
    if (in_t3) begin
      if (bus_fp.req0_ready) fp_acc0++;
      if (bus_fp.req1_ready) fp_r1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request on a port and hold it until it is accepted.
  task automatic issue(input int port, input logic [1:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    bit ok;
    ok = 0;
    if (port == 0) begin v0 = 1; s0 = sel; a0 = a; b0 = b; end
    else           begin v1 = 1; s1 = sel; a1 = a; b1 = b; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = (port == 0) ? bus_rr.req0_ready : bus_rr.req1_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (port == 0) v0 = 0; else v1 = 0;
    if (!ok) chk("issue_accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) for the port's response and compare with a literal.
  task automatic expect_rsp(input int port, input logic [31:0] val, input string name);
    bit got;
    logic [31:0] d;
    got = 0;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus_rr.rsp0_valid : bus_rr.rsp1_valid) begin
        got = 1;
        d = (port == 0) ? bus_rr.rsp0_data : bus_rr.rsp1_data;
        break;
      end
    end
    if (!got) chk({name, "_valid_timeout"}, 32'd0, 32'd1);
    else      chk(name, d, val);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
    s0 = '0; s1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();

    // Ties for four cycles with consumers always ready.
    grant_log.delete();
    v0 = 1; s0 = 2'b01; a0 = 32'h0000_0003; b0 = 32'd1;
    v1 = 1; s1 = 2'b11; a1 = 32'hFFFF_FF00; b1 = 32'd4;
    in_t3 = 1;
    repeat (4) step();
    in_t3 = 0;
    v0 = 0; v1 = 0;
    step(); step();
    chk("t3_grant_count", grant_log.size(), 32'd4);
    if (grant_log.size() >= 4) begin
      chk("t3_grant0", grant_log[0], 32'd0);
      chk("t3_grant1", grant_log[1], 32'd1);
      chk("t3_grant2", grant_log[2], 32'd0);
      chk("t3_grant3", grant_log[3], 32'd1);
    end
    chk("t3_fp_port0_accepts", fp_acc0, 32'd4);
    chk("t3_fp_req1_ready_cycles", fp_r1, 32'd0);

    // Basic shifts on port 0, then port 1.
    issue(0, 2'b01, 32'h0000_0001, 32'd31);
    expect_rsp(0, 32'h8000_0000, "t1_sll31");
    issue(0, 2'b11, 32'h8000_0000, 32'd4);
    expect_rsp(0, 32'hF800_0000, "t2_sra4");
    issue(0, 2'b10, 32'h8000_0000, 32'd4);
    expect_rsp(0, 32'h0800_0000, "t2_srl4");
    issue(0, 2'b10, 32'h8000_0000, 32'h0000_0025);
    expect_rsp(0, 32'h0400_0000, "t2_srl_b25");
    issue(1, 2'b01, 32'h0000_0001, 32'h0000_0021);
    expect_rsp(1, 32'h0000_0002, "t2_p1_sll_b21");

    // Pass-through and zero shift amounts.
    issue(0, 2'b00, 32'hDEAD_BEEF, 32'd7);
    expect_rsp(0, 32'hDEAD_BEEF, "t5_pass");
    issue(1, 2'b11, 32'h8000_0001, 32'd0);
    expect_rsp(1, 32'h8000_0001, "t5_sra0");
    issue(0, 2'b01, 32'h1234_5678, 32'h0000_0020);
    expect_rsp(0, 32'h1234_5678, "t5_sll_b20");

    // Owner back-pressure: result held, no new accepts, nothing lost.
    rr0 = 0;
    issue(0, 2'b01, 32'h0000_00FF, 32'd8);
    expect_rsp(0, 32'h0000_FF00, "t4_first");
    v0 = 1; s0 = 2'b11; a0 = 32'h7000_0000; b0 = 32'd1;
    v1 = 1; s1 = 2'b10; a1 = 32'hF000_0000; b1 = 32'd28;
    repeat (3) step();
    chk("t4_data_stable", bus_rr.rsp0_data, 32'h0000_FF00);
    rr0 = 1;
    step();
    v1 = 0;
    expect_rsp(1, 32'h0000_000F, "t4_p1_after_stall");
    v0 = 0;
    expect_rsp(0, 32'h3800_0000, "t4_p0_after_stall");
    step();

    // Asynchronous reset while a result is pending.
    rr0 = 0;
    issue(0, 2'b01, 32'h0000_000A, 32'd1);
    step();
    #1 rst_n = 0;
    #1;
    chk("t6_rsp0_valid_async", {31'b0, bus_rr.rsp0_valid}, 32'd0);
    chk("t6_busy_async", {31'b0, busy_rr}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    rr0 = 1;
    grant_log.delete();
    v0 = 1; s0 = 2'b10; a0 = 32'h0000_0100; b0 = 32'd8;
    v1 = 1; s1 = 2'b00; a1 = 32'h0000_0005; b1 = 32'd3;
    step();
    v0 = 0;
    step();
    v1 = 0;
    step(); step();
    chk("t6_grant_count", grant_log.size(), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("t6_first_tie", grant_log[0], 32'd0);
      chk("t6_second", grant_log[1], 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
